// File: rtl/delay_assert_slot_scheduler.sv
// Checks "a |-> ##[MIN_DELAY:MAX_DELAY] b" with overlapping attempts, each tracked in one of
// NUM_SLOTS age slots that are allocated, aged, resolved and freed here.
module delay_assert_slot_scheduler #(
    parameter int MIN_DELAY = 1,
    parameter int MAX_DELAY = 3,
    parameter int NUM_SLOTS = 4,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           a,
    input  logic                           b,
    input  logic                           clear_counts,
    output logic                           assertion_pass,
    output logic                           assertion_fail,
    output logic                           assertion_active,
    output logic                           overflow,
    output logic [CNT_W-1:0]               pass_count,
    output logic [CNT_W-1:0]               fail_count,
    output logic [$clog2(NUM_SLOTS+1)-1:0] slots_busy
);
    localparam int AGE_W = $clog2(MAX_DELAY + 1);
    localparam int SB_W  = $clog2(NUM_SLOTS + 1);
    localparam logic [AGE_W-1:0] MIN_A = AGE_W'(MIN_DELAY);
    localparam logic [AGE_W-1:0] MAX_A = AGE_W'(MAX_DELAY);

    logic [NUM_SLOTS-1:0] busy_q;
    logic [AGE_W-1:0]     age_q   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] busy_nxt;
    logic [AGE_W-1:0]     age_nxt [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_pass;
    logic [NUM_SLOTS-1:0] slot_fail;
    logic [AGE_W-1:0]     age_inc;
    logic                 alloc_ok;
    logic                 drop;
    logic [SB_W-1:0]      pass_n;
    logic [SB_W-1:0]      fail_n;
    logic [SB_W-1:0]      busy_cnt;
    logic [CNT_W:0]       pass_sum;
    logic [CNT_W:0]       fail_sum;

    always_comb begin
        busy_nxt  = busy_q;
        age_nxt   = age_q;
        slot_pass = '0;
        slot_fail = '0;
        age_inc   = '0;
        alloc_ok  = 1'b0;
        pass_n    = '0;
        fail_n    = '0;
        busy_cnt  = '0;
        // A busy slot never holds an age above MAX_DELAY-1, so age_inc cannot wrap.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (busy_q[i]) begin
                age_inc = age_q[i] + 1'b1;
                if (b && age_inc >= MIN_A) begin
                    slot_pass[i] = 1'b1;
                end else if (!b && age_inc == MAX_A) begin
                    slot_fail[i] = 1'b1;
                end
                if (slot_pass[i] || slot_fail[i]) begin
                    busy_nxt[i] = 1'b0;
                end else begin
                    age_nxt[i] = age_inc;
                end
            end
        end
        // Allocation looks at busy_q, so a slot freed at this edge is not reused until the next.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (a && en && !alloc_ok && !busy_q[i]) begin
                busy_nxt[i] = 1'b1;
                age_nxt[i]  = '0;
                alloc_ok    = 1'b1;
            end
        end
        drop = a && en && !alloc_ok;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            pass_n   = pass_n + SB_W'(slot_pass[i]);
            fail_n   = fail_n + SB_W'(slot_fail[i]);
            busy_cnt = busy_cnt + SB_W'(busy_nxt[i]);
        end
        pass_sum = {1'b0, pass_count} + (CNT_W+1)'(pass_n);
        fail_sum = {1'b0, fail_count} + (CNT_W+1)'(fail_n);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q           <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) age_q[i] <= '0;
            assertion_pass   <= 1'b0;
            assertion_fail   <= 1'b0;
            assertion_active <= 1'b0;
            overflow         <= 1'b0;
            pass_count       <= '0;
            fail_count       <= '0;
            slots_busy       <= '0;
        end else begin
            busy_q           <= busy_nxt;
            age_q            <= age_nxt;
            assertion_pass   <= |slot_pass;
            assertion_fail   <= |slot_fail;
            assertion_active <= |busy_nxt;
            overflow         <= drop;
            slots_busy       <= busy_cnt;
            if (clear_counts) begin
                pass_count <= '0;
                fail_count <= '0;
            end else begin
                pass_count <= pass_sum[CNT_W] ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
                fail_count <= fail_sum[CNT_W] ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_delay_assert_slot_scheduler.sv
// Bench for delay_assert_slot_scheduler: a 4-slot/16-bit instance and a 2-slot/3-bit instance
// driven together and compared against an attempt-list reference model.
module tb_delay_assert_slot_scheduler;
    localparam int MIN_D = 1;
    localparam int MAX_D = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0, a = 1'b0, b = 1'b0, clear_counts = 1'b0;

    logic p0, f0, act0, ov0;
    logic [15:0] pc0, fc0;
    logic [2:0]  sb0;
    logic p1, f1, act1, ov1;
    logic [2:0] pc1, fc1;
    logic [1:0] sb1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: per instance, the list of start cycles of attempts in flight.
    int mq [2][$];
    int e_pass [2], e_fail [2], e_act [2], e_ov [2], e_pc [2], e_fc [2], e_sb [2];

    always #5 clk = ~clk;

    delay_assert_slot_scheduler #(.MIN_DELAY(MIN_D), .MAX_DELAY(MAX_D), .NUM_SLOTS(4), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clear_counts(clear_counts),
        .assertion_pass(p0), .assertion_fail(f0), .assertion_active(act0), .overflow(ov0),
        .pass_count(pc0), .fail_count(fc0), .slots_busy(sb0)
    );

    delay_assert_slot_scheduler #(.MIN_DELAY(MIN_D), .MAX_DELAY(MAX_D), .NUM_SLOTS(2), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .clear_counts(clear_counts),
        .assertion_pass(p1), .assertion_fail(f1), .assertion_active(act1), .overflow(ov1),
        .pass_count(pc1), .fail_count(fc1), .slots_busy(sb1)
    );

    task automatic model_step(input int k, input int nslots, input int cmax);
        int keep [$];
        int p, f, prior, d;
        if (!rst) begin
            mq[k].delete();
            e_pass[k] = 0; e_fail[k] = 0; e_act[k] = 0; e_ov[k] = 0;
            e_pc[k] = 0; e_fc[k] = 0; e_sb[k] = 0;
            return;
        end
        p = 0; f = 0;
        prior = mq[k].size();
        for (int j = 0; j < mq[k].size(); j++) begin
            d = cyc - mq[k][j];
            if (b && d >= MIN_D && d <= MAX_D) p++;
            else if (!b && d == MAX_D) f++;
            else keep.push_back(mq[k][j]);
        end
        mq[k] = keep;
        e_ov[k] = 0;
        if (a && en) begin
            if (prior < nslots) mq[k].push_back(cyc);
            else e_ov[k] = 1;
        end
        e_pass[k] = (p > 0) ? 1 : 0;
        e_fail[k] = (f > 0) ? 1 : 0;
        e_sb[k] = mq[k].size();
        e_act[k] = (e_sb[k] > 0) ? 1 : 0;
        if (clear_counts) begin
            e_pc[k] = 0; e_fc[k] = 0;
        end else begin
            e_pc[k] = (e_pc[k] + p > cmax) ? cmax : e_pc[k] + p;
            e_fc[k] = (e_fc[k] + f > cmax) ? cmax : e_fc[k] + f;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 4, 65535);
        model_step(1, 2, 7);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; a = 1'b1; en = 1'b1; b = 1'b1;
        tick(); tick();
        checks++;
        if ({p0, f0, act0, ov0, pc0, fc0, sb0} !== '0) begin
            failures++; $display("FAIL reset_dut0: outs=%h required 0", {p0, f0, act0, ov0, pc0, fc0, sb0});
        end
        checks++;
        if ({p1, f1, act1, ov1, pc1, fc1, sb1} !== '0) begin
            failures++; $display("FAIL reset_dut1: outs=%h required 0", {p1, f1, act1, ov1, pc1, fc1, sb1});
        end
        rst = 1'b1; a = 1'b0; b = 1'b0;
        tick(); tick();
    endtask

    task automatic test_single_pass();
        a = 1'b1; tick(); a = 1'b0;
        checks++;
        if (act0 !== 1'b1 || p0 !== 1'b0) begin
            failures++; $display("FAIL pass_start: active=%b pass=%b required 1 0", act0, p0);
        end
        tick();
        checks++;
        if (act0 !== 1'b1 || p0 !== 1'b0) begin
            failures++; $display("FAIL pass_wait: active=%b pass=%b required 1 0", act0, p0);
        end
        b = 1'b1; tick(); b = 1'b0;
        checks++;
        if (p0 !== 1'b1 || pc0 !== 16'd1 || act0 !== 1'b0) begin
            failures++; $display("FAIL pass_hit: pass=%b count=%0d active=%b required 1 1 0", p0, pc0, act0);
        end
        tick();
        checks++;
        if (p0 !== 1'b0) begin
            failures++; $display("FAIL pass_pulse: pass=%b required 0", p0);
        end
    endtask

    task automatic test_single_fail();
        a = 1'b1; b = 1'b0; tick(); a = 1'b0;
        tick(); tick();
        checks++;
        if (f0 !== 1'b0 || act0 !== 1'b1) begin
            failures++; $display("FAIL fail_early: fail=%b active=%b required 0 1", f0, act0);
        end
        tick();
        checks++;
        if (f0 !== 1'b1 || fc0 !== 16'd1 || act0 !== 1'b0) begin
            failures++; $display("FAIL fail_hit: fail=%b count=%0d active=%b required 1 1 0", f0, fc0, act0);
        end
        tick();
    endtask

    task automatic test_self_b();
        a = 1'b1; b = 1'b1; tick(); a = 1'b0;
        checks++;
        if (p0 !== 1'b0 || act0 !== 1'b1) begin
            failures++; $display("FAIL self_b_start: pass=%b active=%b required 0 1", p0, act0);
        end
        tick(); b = 1'b0;
        checks++;
        if (p0 !== 1'b1 || pc0 !== 16'd2) begin
            failures++; $display("FAIL self_b_next: pass=%b count=%0d required 1 2", p0, pc0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        a = 1'b1; tick(); tick(); a = 1'b0;
        checks++;
        if (sb0 !== 3'd2) begin
            failures++; $display("FAIL b2b_busy: slots_busy=%0d required 2", sb0);
        end
        b = 1'b1; tick(); b = 1'b0;
        checks++;
        if (p0 !== 1'b1 || pc0 !== 16'd4 || sb0 !== 3'd0) begin
            failures++; $display("FAIL b2b_pass: pass=%b count=%0d busy=%0d required 1 4 0", p0, pc0, sb0);
        end
        tick();
        checks++;
        if (p0 !== 1'b0) begin
            failures++; $display("FAIL b2b_pulse: pass=%b required 0", p0);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] ov_seen, f_seen;
        b = 1'b0; a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            ov_seen[i] = ov1; f_seen[i] = f1;
        end
        a = 1'b0;
        checks++;
        if (ov_seen !== 4'b1100) begin
            failures++; $display("FAIL overflow_pulses: seen=%b required 1100", ov_seen);
        end
        checks++;
        if (ov0 !== 1'b0) begin
            failures++; $display("FAIL overflow_wide: overflow=%b required 0", ov0);
        end
        tick();
        checks++;
        if ({f1, f_seen} !== 5'b11000 || ov1 !== 1'b0) begin
            failures++; $display("FAIL overflow_fails: seen=%b ov=%b required 11000 0", {f1, f_seen}, ov1);
        end
        tick(); tick();
    endtask

    task automatic test_reset_midflight();
        b = 1'b0; a = 1'b1; tick(); tick(); a = 1'b0;
        rst = 1'b0; tick(); rst = 1'b1;
        checks++;
        if ({p0, f0, act0, ov0, pc0, fc0, sb0} !== '0) begin
            failures++; $display("FAIL mid_reset: outs=%h required 0", {p0, f0, act0, ov0, pc0, fc0, sb0});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (f0 !== 1'b0 || act0 !== 1'b0) begin
                failures++; $display("FAIL mid_reset_after: fail=%b active=%b required 0 0", f0, act0);
            end
        end
    endtask

    task automatic test_clear();
        a = 1'b1; tick(); a = 1'b0;
        b = 1'b1; clear_counts = 1'b1; tick(); b = 1'b0; clear_counts = 1'b0;
        checks++;
        if (p0 !== 1'b1 || pc0 !== 16'd0) begin
            failures++; $display("FAIL clear_at_pass: pass=%b count=%0d required 1 0", p0, pc0);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            en = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 1) == 1);
            b = ($urandom_range(0, 2) == 0);
            clear_counts = ($urandom_range(0, 49) == 0);
            tick();
            checks++;
            if (p0 !== e_pass[0][0] || f0 !== e_fail[0][0] || act0 !== e_act[0][0] || ov0 !== e_ov[0][0]) begin
                failures++;
                $display("FAIL rnd_flags0 cyc %0d: p f act ov=%b%b%b%b required %0d%0d%0d%0d",
                         cyc, p0, f0, act0, ov0, e_pass[0], e_fail[0], e_act[0], e_ov[0]);
            end
            checks++;
            if (int'(pc0) != e_pc[0] || int'(fc0) != e_fc[0] || int'(sb0) != e_sb[0]) begin
                failures++;
                $display("FAIL rnd_counts0 cyc %0d: pc fc sb=%0d %0d %0d required %0d %0d %0d",
                         cyc, pc0, fc0, sb0, e_pc[0], e_fc[0], e_sb[0]);
            end
            checks++;
            if (p1 !== e_pass[1][0] || f1 !== e_fail[1][0] || act1 !== e_act[1][0] || ov1 !== e_ov[1][0]) begin
                failures++;
                $display("FAIL rnd_flags1 cyc %0d: p f act ov=%b%b%b%b required %0d%0d%0d%0d",
                         cyc, p1, f1, act1, ov1, e_pass[1], e_fail[1], e_act[1], e_ov[1]);
            end
            checks++;
            if (int'(pc1) != e_pc[1] || int'(fc1) != e_fc[1] || int'(sb1) != e_sb[1]) begin
                failures++;
                $display("FAIL rnd_counts1 cyc %0d: pc fc sb=%0d %0d %0d required %0d %0d %0d",
                         cyc, pc1, fc1, sb1, e_pc[1], e_fc[1], e_sb[1]);
            end
        end
        rst = 1'b1; a = 1'b0; clear_counts = 1'b0;
    endtask

    initial begin
        test_reset();
        en = 1'b1;
        test_single_pass();
        test_single_fail();
        test_self_b();
        test_back_to_back();
        test_overflow();
        test_reset_midflight();
        test_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
